// File: rtl/bms_protection_fsm_if.sv
// Measurement/request bundle between the BMS front end and the protection FSM,
// plus the FET request outputs returned to the gate-drive side.
interface bms_protection_fsm_if #(
  parameter int VW = 16,
  parameter int IW = 16,
  parameter int TW = 8
);
  logic                 sample_valid;
  logic [VW-1:0]        vcell_max;
  logic [VW-1:0]        vcell_min;
  logic signed [IW-1:0] pack_current;
  logic signed [TW-1:0] temp_max;
  logic                 charger_present;
  logic                 load_request;
  logic                 fault_clear;
  logic                 charge_en_fsm;
  logic                 discharge_en_fsm;
  logic                 system_fault;
  logic [3:0]           fault_code;
  logic [1:0]           state;

  modport master (
    output sample_valid, vcell_max, vcell_min, pack_current, temp_max,
           charger_present, load_request, fault_clear,
    input  charge_en_fsm, discharge_en_fsm, system_fault, fault_code, state
  );

  modport slave (
    input  sample_valid, vcell_max, vcell_min, pack_current, temp_max,
           charger_present, load_request, fault_clear,
    output charge_en_fsm, discharge_en_fsm, system_fault, fault_code, state
  );
endinterface

// File: rtl/bms_protection_fsm.sv
// Pack protection controller: debounces OV/UV/OC/OT and runs the
// IDLE/CHARGE/DISCHARGE/FAULT mode machine feeding the FET gate drive.
module bms_protection_fsm #(
  parameter int VW        = 16,
  parameter int IW        = 16,
  parameter int TW        = 8,
  parameter int OV_TH     = 4200,
  parameter int UV_TH     = 2800,
  parameter int OC_CHG_TH = 20000,
  parameter int OC_DSG_TH = 30000,
  parameter int OT_TH     = 60,
  parameter int DEBOUNCE  = 4,
  parameter int RECOVER   = 8
) (
  input  logic clk,
  input  logic rst_n,
  bms_protection_fsm_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, CHARGE = 2'd1, DISCHARGE = 2'd2, FAULT = 2'd3} state_e;

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int RW = $clog2(RECOVER + 1);
  localparam logic [CW-1:0]        DB_MAX   = CW'(DEBOUNCE);
  localparam logic [RW-1:0]        RC_MAX   = RW'(RECOVER);
  localparam logic [VW-1:0]        OV_T     = VW'(OV_TH);
  localparam logic [VW-1:0]        UV_T     = VW'(UV_TH);
  // One extra bit so -OC_DSG_TH is representable at any IW.
  localparam logic signed [IW:0]   OC_CHG   = (IW+1)'(OC_CHG_TH);
  localparam logic signed [IW:0]   OC_DSG_N = (IW+1)'(-OC_DSG_TH);
  localparam logic signed [TW-1:0] OT_T     = TW'(OT_TH);

  state_e               state_q, state_d;
  logic [3:0][CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]        rec_q, rec_d;
  logic [3:0]           fc_q, fc_d;
  logic                 chg_en_q, chg_en_d;
  logic                 dsg_en_q, dsg_en_d;
  logic                 flt_q, flt_d;
  logic [3:0]           cond;
  logic [3:0]           hit;
  logic                 trip;
  logic signed [IW:0]   cur_x;

  // Bit order {OT, OC, UV, OV} matches fault_code.
  always_comb begin
    cur_x   = $signed({bus.pack_current[IW-1], bus.pack_current});
    cond[0] = bus.sample_valid && (bus.vcell_max > OV_T);
    cond[1] = bus.sample_valid && (bus.vcell_min < UV_T);
    cond[2] = bus.sample_valid && ((cur_x > OC_CHG) || (cur_x < OC_DSG_N));
    cond[3] = bus.sample_valid && ($signed(bus.temp_max) > OT_T);
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bus.sample_valid) begin
        if (!cond[i])              cnt_d[i] = '0;
        else if (cnt_q[i] != DB_MAX) cnt_d[i] = cnt_q[i] + CW'(1);
      end
      hit[i] = (cnt_q[i] == DB_MAX);
    end
    trip = |hit;
  end

  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    rec_d   = '0;
    case (state_q)
      IDLE: begin
        if (trip)                     state_d = FAULT;
        else if (bus.charger_present) state_d = CHARGE;
        else if (bus.load_request)    state_d = DISCHARGE;
      end
      CHARGE: begin
        if (trip)                      state_d = FAULT;
        else if (!bus.charger_present) state_d = IDLE;
      end
      DISCHARGE: begin
        if (trip)                                          state_d = FAULT;
        else if (!bus.load_request || bus.charger_present) state_d = IDLE;
      end
      FAULT: begin
        rec_d = rec_q;
        if (bus.sample_valid) begin
          if (|cond)                rec_d = '0;
          else if (rec_q != RC_MAX) rec_d = rec_q + RW'(1);
        end
        if (bus.fault_clear && (rec_q == RC_MAX)) state_d = IDLE;
      end
    endcase

    if (state_q != FAULT) begin
      if (trip) fc_d = hit;
    end else if (state_d == IDLE) begin
      fc_d = '0;
    end else begin
      fc_d = fc_q | hit;
    end

    chg_en_d = (state_d == CHARGE);
    dsg_en_d = (state_d == DISCHARGE);
    flt_d    = (state_d == FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rec_q    <= '0;
      fc_q     <= '0;
      chg_en_q <= 1'b0;
      dsg_en_q <= 1'b0;
      flt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rec_q    <= rec_d;
      fc_q     <= fc_d;
      chg_en_q <= chg_en_d;
      dsg_en_q <= dsg_en_d;
      flt_q    <= flt_d;
    end
  end

  assign bus.state            = state_q;
  assign bus.fault_code       = fc_q;
  assign bus.charge_en_fsm    = chg_en_q;
  assign bus.discharge_en_fsm = dsg_en_q;
  assign bus.system_fault     = flt_q;
endmodule

// File: tb/tb_bms_protection_fsm.sv
// Directed bench for bms_protection_fsm: trip/debounce, recovery, arbitration, async reset.
module tb_bms_protection_fsm;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;

  bms_protection_fsm_if bus ();

  bms_protection_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clean();
    bus.sample_valid = 1'b1;
    bus.vcell_max    = 16'd3700;
    bus.vcell_min    = 16'd3600;
    bus.pack_current = 16'sd0;
    bus.temp_max     = 8'sd25;
  endtask

  task automatic outs(input string tag, input logic [1:0] st, input logic ce,
                      input logic de, input logic sf, input logic [3:0] fc);
    check({tag, ".state"}, 32'(bus.state), 32'(st));
    check({tag, ".chg_en"}, 32'(bus.charge_en_fsm), 32'(ce));
    check({tag, ".dsg_en"}, 32'(bus.discharge_en_fsm), 32'(de));
    check({tag, ".sys_fault"}, 32'(bus.system_fault), 32'(sf));
    check({tag, ".fault_code"}, 32'(bus.fault_code), 32'(fc));
  endtask

  initial begin
    clean();
    bus.charger_present = 1'b0;
    bus.load_request    = 1'b0;
    bus.fault_clear     = 1'b0;
    rst_n = 1'b0;
    tick(2);
    outs("reset", 2'd0, 1'b0, 1'b0, 1'b0, 4'h0);
    rst_n = 1'b1;
    tick(1);
    outs("idle_after_reset", 2'd0, 1'b0, 1'b0, 1'b0, 4'h0);

    // OV debounce trip from CHARGE
    bus.charger_present = 1'b1;
    tick(1);
    outs("enter_charge", 2'd1, 1'b1, 1'b0, 1'b0, 4'h0);
    bus.vcell_max = 16'd4300;
    tick(4);
    outs("ov_4th_sample", 2'd1, 1'b1, 1'b0, 1'b0, 4'h0);
    clean();
    bus.charger_present = 1'b0;
    tick(1);
    outs("ov_trip", 2'd3, 1'b0, 1'b0, 1'b1, 4'b0001);

    // Recovery: bad sample at clean sample 5 restarts the count
    bus.fault_clear = 1'b1;
    tick(4);
    bus.vcell_max = 16'd4300;
    tick(1);
    clean();
    tick(7);
    outs("recover_7", 2'd3, 1'b0, 1'b0, 1'b1, 4'b0001);
    tick(1);
    outs("recover_8", 2'd3, 1'b0, 1'b0, 1'b1, 4'b0001);
    tick(1);
    outs("recover_exit", 2'd0, 1'b0, 1'b0, 1'b0, 4'h0);
    bus.fault_clear = 1'b0;

    // UV glitch rejection
    bus.vcell_min = 16'd2700;
    for (int i = 0; i < 3; i++) begin tick(1); check("glitch_a", 32'(bus.state), 32'd0); end
    clean();
    tick(1);
    check("glitch_clean", 32'(bus.state), 32'd0);
    bus.vcell_min = 16'd2700;
    for (int i = 0; i < 3; i++) begin tick(1); check("glitch_b", 32'(bus.state), 32'd0); end
    clean();
    tick(1);

    // Arbitration
    bus.charger_present = 1'b1;
    bus.load_request    = 1'b1;
    tick(1);
    outs("arb_both", 2'd1, 1'b1, 1'b0, 1'b0, 4'h0);
    bus.charger_present = 1'b0;
    tick(1);
    outs("chg_release", 2'd0, 1'b0, 1'b0, 1'b0, 4'h0);
    tick(1);
    outs("enter_dsg", 2'd2, 1'b0, 1'b1, 1'b0, 4'h0);
    bus.charger_present = 1'b1;
    tick(1);
    outs("dsg_to_idle", 2'd0, 1'b0, 1'b0, 1'b0, 4'h0);
    tick(1);
    outs("idle_to_chg", 2'd1, 1'b1, 1'b0, 1'b0, 4'h0);
    bus.charger_present = 1'b0;
    tick(2);
    outs("back_to_dsg", 2'd2, 1'b0, 1'b1, 1'b0, 4'h0);

    // Discharge OC boundary: -30000 is legal
    bus.pack_current = -16'sd30000;
    tick(5);
    outs("oc_boundary", 2'd2, 1'b0, 1'b1, 1'b0, 4'h0);
    // -30001 with an invalid gap inside the run
    bus.pack_current = -16'sd30001;
    tick(2);
    bus.sample_valid = 1'b0;
    tick(1);
    bus.sample_valid = 1'b1;
    tick(2);
    outs("oc_gap_4th", 2'd2, 1'b0, 1'b1, 1'b0, 4'h0);
    bus.pack_current = 16'sd0;
    tick(1);
    outs("oc_trip", 2'd3, 1'b0, 1'b0, 1'b1, 4'b0100);

    // Trip plus request while in FAULT: stays, OT ORed in
    bus.charger_present = 1'b1;
    bus.fault_clear     = 1'b1;
    bus.temp_max        = 8'sd70;
    tick(5);
    outs("fault_ot_req", 2'd3, 1'b0, 1'b0, 1'b1, 4'b1100);

    // Async reset without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    outs("async_reset", 2'd0, 1'b0, 1'b0, 1'b0, 4'h0);
    clean();
    bus.charger_present = 1'b0;
    bus.load_request    = 1'b0;
    bus.fault_clear     = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    outs("post_reset", 2'd0, 1'b0, 1'b0, 1'b0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
